coupler_n: RTL and testbench
============================

Name: coupler_n

Overview:
- Parametrised successor to the two-way record coupler.
- Packs P_RATIO consecutive P_WIDTH records from a merger output stream into one P_RATIO*P_WIDTH word, then buffers the word in an internal output FIFO for the wide downstream consumer (memory writer or wider merger).
- An all-zero record is the stream terminator. On a terminator the partial word is closed and its remaining upper lanes are zero-padded, so the terminator is never split across words.

Parameters:
- P_WIDTH, 32, record width in bits.
- P_RATIO, 4, records per output word; power of two, >= 2.
- P_DEPTH, 16, output FIFO depth in words; power of two, >= 2.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_data  input  P_WIDTH  incoming record; all-zero = terminator.
- i_enq  input  1  push i_data; ignored while o_full=1.
- o_full  output  1  input side cannot accept this cycle.
- o_data  output  P_RATIO*P_WIDTH  head word of output FIFO; lane k = bits [k*P_WIDTH +: P_WIDTH].
- i_deq  input  1  pop head word; ignored while o_empty=1.
- o_empty  output  1  output FIFO empty.
- o_count  output  clog2(P_DEPTH+1)  output FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - lane index = 0; lane registers = 0; FIFO pointers = 0.
  - o_empty=1, o_full=0, o_count=0, o_data=0.
- Accept condition: acc = i_enq & ~o_full.
- o_full = (o_count == P_DEPTH). This is conservative: it holds off input even when the record would not complete a word. There is no combinational path from i_data or i_deq to o_full.
- State: lane index idx in 0..P_RATIO-1, plus P_RATIO-1 lane registers.
- On acc with i_data != 0 and idx < P_RATIO-1: lane[idx] <= i_data; idx <= idx+1.
- On acc with i_data != 0 and idx == P_RATIO-1: enqueue the word {i_data, lane[P_RATIO-2..0]}; idx <= 0.
- On acc with i_data == 0 (terminator) at any idx:
  - enqueue a word with lanes 0..idx-1 = stored lanes and lanes idx..P_RATIO-1 = 0; idx <= 0.
  - Terminator at idx=0 enqueues an all-zero word.
- After a word is enqueued, its lane registers clear to 0, so no stale data appears in a later padded word.
- Output FIFO is first-word-fall-through:
  - a word enqueued in cycle t is visible on o_data with o_empty=0 from cycle t+1;
  - o_data = 0 whenever o_empty=1.
- Simultaneous enqueue and dequeue: occupancy unchanged and pointers advance. With FIFO full, the input is already blocked, so the simultaneous case cannot occur at full.
- Pointer wrap: modulo P_DEPTH; full/empty derived from o_count, not pointer equality.
- i_deq while empty and i_enq while full: no state change, no error flag.
- Reset mid-word discards the partial word and all buffered words.
- Records are never reordered; lane 0 holds the earliest record.

Test Plan (P_WIDTH=8, P_RATIO=4, P_DEPTH=4 unless stated):
- Fill and drain:
  - stimulus: push 01,02,03,04, then 05..08.
  - response: o_data=0x04030201 one cycle after the 4th push, then 0x08070605; o_count=2.
- Terminator mid-word:
  - stimulus: push 11,22,00.
  - response: one word 0x00002211; idx back to 0; next push 33 starts a fresh word in lane 0.
- Terminator at lane 0:
  - stimulus: push 00 with idx=0.
  - response: word 0x00000000 enqueued; o_empty falls next cycle.
- Backpressure:
  - stimulus: enqueue 4 full words without deq.
  - response: o_full=1, o_count=4; a further i_enq with 99 is ignored.
  - then one i_deq: o_full falls next cycle and 99 is then accepted into lane 0.
- Concurrent push and pop:
  - stimulus: o_count=2; in the same cycle complete a word and assert i_deq.
  - response: o_count stays 2 and head order is preserved.
- Async reset:
  - stimulus: assert i_rst between clock edges with idx=2 and o_count=3.
  - response: o_empty=1 and o_count=0 immediately, before the next edge; the first post-reset word contains only post-reset records.

Source files
------------

// File: rtl/coupler_n.sv
// Packs P_RATIO narrow records into one wide word and buffers words in a FWFT FIFO.
// An all-zero record terminates the stream and closes the partial word with zero padding.
module coupler_n #(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_RATIO = 4,
  parameter int unsigned P_DEPTH = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [P_WIDTH-1:0]                 i_data,
  input  logic                               i_enq,
  output logic                               o_full,
  output logic [P_RATIO*P_WIDTH-1:0]         o_data,
  input  logic                               i_deq,
  output logic                               o_empty,
  output logic [$clog2(P_DEPTH+1)-1:0]       o_count
);

  localparam int unsigned IdxW  = $clog2(P_RATIO);
  localparam int unsigned PtrW  = $clog2(P_DEPTH);
  localparam int unsigned CntW  = $clog2(P_DEPTH + 1);
  localparam int unsigned WordW = P_RATIO * P_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(P_RATIO - 1);

  logic [IdxW-1:0]    idx_q, idx_d;
  logic [P_WIDTH-1:0] lane_q [P_RATIO-1];
  logic [P_WIDTH-1:0] lane_d [P_RATIO-1];
  logic [WordW-1:0]   mem_q  [P_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic             acc, term, push, pop;
  logic [WordW-1:0] word;

  always_comb begin
    acc  = i_enq & ~o_full;
    term = (i_data == '0);
    push = acc & (term | (idx_q == LastIdx));
    pop  = i_deq & ~o_empty;

    // Only lanes below idx hold live records; the rest stay zero-padded.
    word = '0;
    for (int k = 0; k < int'(P_RATIO) - 1; k++) begin
      if (k < int'(idx_q)) word[k*P_WIDTH +: P_WIDTH] = lane_q[k];
    end
    if (!term) word[(P_RATIO-1)*P_WIDTH +: P_WIDTH] = i_data;

    lane_d = lane_q;
    idx_d  = idx_q;
    if (push) begin
      for (int k = 0; k < int'(P_RATIO) - 1; k++) lane_d[k] = '0;
      idx_d = '0;
    end else if (acc) begin
      for (int k = 0; k < int'(P_RATIO) - 1; k++) begin
        if (k == int'(idx_q)) lane_d[k] = i_data;
      end
      idx_d = idx_q + IdxW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q    <= '0;
      for (int k = 0; k < int'(P_RATIO) - 1; k++) lane_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: o_data is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign o_full  = (cnt_q == CntW'(P_DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_coupler_n.sv
// Directed bench for coupler_n: a record-packing model feeds a scoreboard queue of expected words.
module tb_coupler_n;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_enq = 1'b0;
  logic        o_full;
  logic [31:0] o_data;
  logic        i_deq = 1'b0;
  logic        o_empty;
  logic [2:0]  o_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb [$];
  logic [7:0]  m_lane [3];
  int          m_idx = 0;

  coupler_n #(.P_WIDTH(8), .P_RATIO(4), .P_DEPTH(4)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data (i_data),
    .i_enq  (i_enq),
    .o_full (o_full),
    .o_data (o_data),
    .i_deq  (i_deq),
    .o_empty(o_empty),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_idx = 0;
    for (int k = 0; k < 3; k++) m_lane[k] = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".count"}, 32'(o_count), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(o_empty), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(o_full),  32'(sb.size() == 4));
    chk({tag, ".data"},  o_data, (sb.size() == 0) ? 32'h0 : sb[0]);
  endtask

  // Called just after a falling edge; drives one cycle and checks after the next falling edge.
  task automatic step(input logic enq, input logic [7:0] d, input logic deq, input string tag);
    logic        full_m;
    logic [31:0] w;
    full_m = (sb.size() == 4);
    i_enq  = enq;
    i_data = d;
    i_deq  = deq;
    if (deq && sb.size() > 0) void'(sb.pop_front());
    if (enq && !full_m) begin
      if (d == 8'h00 || m_idx == 3) begin
        w = {(d == 8'h00) ? 8'h00 : d, m_lane[2], m_lane[1], m_lane[0]};
        sb.push_back(w);
        for (int k = 0; k < 3; k++) m_lane[k] = '0;
        m_idx = 0;
      end else begin
        m_lane[m_idx] = d;
        m_idx++;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_enq = 1'b0;
    i_deq = 1'b0;
    chk_outputs(tag);
  endtask

  initial begin
    model_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rst.empty", 32'(o_empty), 32'd1);
    chk("rst.full",  32'(o_full),  32'd0);
    chk("rst.count", 32'(o_count), 32'd0);
    chk("rst.data",  o_data,       32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Fill and drain
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("fill.word0", o_data, 32'h04030201);
    for (int i = 5; i <= 8; i++) step(1'b1, 8'(i), 1'b0, "fill");
    chk("fill.count2", 32'(o_count), 32'd2);
    step(1'b0, 8'h00, 1'b1, "drain");
    chk("drain.word1", o_data, 32'h08070605);
    step(1'b0, 8'h00, 1'b1, "drain");
    step(1'b0, 8'h00, 1'b1, "deq_empty");

    // Terminator mid-word, then a fresh word starting in lane 0
    step(1'b1, 8'h11, 1'b0, "term");
    step(1'b1, 8'h22, 1'b0, "term");
    step(1'b1, 8'h00, 1'b0, "term");
    chk("term.word", o_data, 32'h00002211);
    step(1'b1, 8'h33, 1'b0, "term");
    step(1'b1, 8'h00, 1'b1, "term");
    chk("term.fresh", o_data, 32'h00000033);
    step(1'b0, 8'h00, 1'b1, "term");

    // Terminator at lane 0
    step(1'b1, 8'h00, 1'b0, "term0");
    chk("term0.empty", 32'(o_empty), 32'd0);
    chk("term0.data",  o_data,       32'h0);
    step(1'b0, 8'h00, 1'b1, "term0");

    // Backpressure
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "bp");
    chk("bp.full",  32'(o_full),  32'd1);
    chk("bp.count", 32'(o_count), 32'd4);
    step(1'b1, 8'h99, 1'b0, "bp.ignored");
    step(1'b0, 8'h00, 1'b1, "bp.deq");
    chk("bp.full_fell", 32'(o_full), 32'd0);
    step(1'b1, 8'h99, 1'b0, "bp.accept");
    step(1'b1, 8'hAA, 1'b0, "bp.accept");
    step(1'b1, 8'hBB, 1'b0, "bp.accept");
    step(1'b1, 8'hCC, 1'b0, "bp.accept");
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "bp.drain");
    chk("bp.last", o_data, 32'hCCBBAA99);
    step(1'b0, 8'h00, 1'b1, "bp.drain");

    // Concurrent push and pop at occupancy 2
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h60 + i), 1'b0, "cc");
    step(1'b1, 8'h6B, 1'b1, "cc.both");
    chk("cc.count", 32'(o_count), 32'd2);
    chk("cc.head",  o_data,       32'h67666564);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, "cc.drain");

    // Async reset with idx=2 and three buffered words
    for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h80 + i), 1'b0, "ar");
    chk("ar.pre_count", 32'(o_count), 32'd3);
    #2 i_rst = 1'b1;
    #1;
    chk("ar.empty_now", 32'(o_empty), 32'd1);
    chk("ar.count_now", 32'(o_count), 32'd0);
    chk("ar.data_now",  o_data,       32'h0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "ar.post");
    chk("ar.post_word", o_data, 32'h44434241);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
